// File: rtl/vend_pkg.sv
`default_nettype none
// vend_pkg: FSM state type, default price/coin tables and change-coin selection
// shared by the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vend_state_t;

  localparam int DEF_PW = 7;
  localparam logic [5*DEF_PW-1:0] DEF_PRICES   = {7'd8, 7'd10, 7'd6, 7'd5, 7'd7};
  localparam logic [4*DEF_PW-1:0] DEF_COIN_VAL = {7'd20, 7'd10, 7'd5, 7'd1};

  // One-hot of the largest coin value not exceeding credit; zero when none fits.
  function automatic logic [3:0] largest_coin(input int unsigned credit,
                                              input int unsigned v0,
                                              input int unsigned v1,
                                              input int unsigned v2,
                                              input int unsigned v3);
    int unsigned vals [4];
    int unsigned best;
    logic [3:0]  sel;
    vals = '{v0, v1, v2, v3};
    best = 0;
    sel  = '0;
    for (int k = 0; k < 4; k++) begin
      if (vals[k] != 0 && vals[k] <= credit && vals[k] > best) begin
        best   = vals[k];
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_edge_det.sv
`default_nettype none
// vend_edge_det: registers each input bit once and flags its 0->1 transitions.
module vend_edge_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '0;
    else      prev <= din;
  end

  assign rise = din & ~prev;

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// vend_ctrl_multi: coin credit, wrap-around menu selection, vend handshake and
// coin-by-coin change return for an N_ITEMS vending machine.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                        N_ITEMS    = 5,
  parameter int                        PW         = DEF_PW,
  parameter logic [N_ITEMS*PW-1:0]     PRICES     = DEF_PRICES,
  parameter int                        MAX_CREDIT = 99,
  parameter logic [4*PW-1:0]           COIN_VAL   = DEF_COIN_VAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 coin_in,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_confirm,
  input  logic                       btn_cancel,
  output logic [PW-1:0]              credit,
  output logic [$clog2(N_ITEMS)-1:0] sel_idx,
  output logic [PW-1:0]              sel_price,
  output logic [N_ITEMS-1:0]         afford,
  output logic                       vend_valid,
  output logic [$clog2(N_ITEMS)-1:0] vend_idx,
  input  logic                       vend_ready,
  output logic                       chg_valid,
  output logic [3:0]                 chg_coin,
  input  logic                       chg_ready,
  output logic                       coin_reject,
  output logic                       busy
);

  localparam int          IW   = $clog2(N_ITEMS);
  localparam logic [PW:0] MAXC = (PW+1)'(MAX_CREDIT);
  localparam int unsigned CV0  = 32'(COIN_VAL[0*PW +: PW]);
  localparam int unsigned CV1  = 32'(COIN_VAL[1*PW +: PW]);
  localparam int unsigned CV2  = 32'(COIN_VAL[2*PW +: PW]);
  localparam int unsigned CV3  = 32'(COIN_VAL[3*PW +: PW]);

  logic [3:0]  coin_ev;
  logic [3:0]  btn_ev;
  logic        left_ev, right_ev, confirm_ev, cancel_ev;

  vend_edge_det #(.WIDTH(4)) u_coin_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (coin_in),
    .rise (coin_ev)
  );

  vend_edge_det #(.WIDTH(4)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({btn_cancel, btn_confirm, btn_right, btn_left}),
    .rise (btn_ev)
  );

  assign left_ev    = btn_ev[0];
  assign right_ev   = btn_ev[1];
  assign confirm_ev = btn_ev[2];
  assign cancel_ev  = btn_ev[3];

  vend_state_t state;

  logic [PW-1:0] coin_val;
  logic          multi_coin;
  logic [PW:0]   coin_sum;
  logic [PW-1:0] vend_price, vend_rem;
  logic [PW-1:0] chg_val, chg_rem;
  logic [3:0]    cancel_coin, vend_coin, next_coin;

  // Ascending scan so the highest-index coin edge wins.
  always_comb begin
    coin_val = '0;
    chg_val  = '0;
    for (int k = 0; k < 4; k++) begin
      if (coin_ev[k])  coin_val = COIN_VAL[k*PW +: PW];
      if (chg_coin[k]) chg_val  = COIN_VAL[k*PW +: PW];
    end
    multi_coin  = ($countones(coin_ev) > 1);
    coin_sum    = {1'b0, credit} + {1'b0, coin_val};
    vend_price  = PRICES[vend_idx*PW +: PW];
    vend_rem    = credit - vend_price;
    chg_rem     = credit - chg_val;
    cancel_coin = largest_coin(32'(credit),   CV0, CV1, CV2, CV3);
    vend_coin   = largest_coin(32'(vend_rem), CV0, CV1, CV2, CV3);
    next_coin   = largest_coin(32'(chg_rem),  CV0, CV1, CV2, CV3);
  end

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_afford
    assign afford[i] = (credit >= PRICES[i*PW +: PW]);
  end

  assign sel_price = PRICES[sel_idx*PW +: PW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= '0;
      sel_idx     <= '0;
      vend_valid  <= 1'b0;
      vend_idx    <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= '0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_ev) begin
            coin_reject <= |coin_ev;
            if (credit != '0) begin
              state     <= CHANGE;
              busy      <= 1'b1;
              chg_valid <= 1'b1;
              chg_coin  <= cancel_coin;
            end
          end else if (confirm_ev) begin
            coin_reject <= |coin_ev;
            if (afford[sel_idx]) begin
              state      <= VEND;
              busy       <= 1'b1;
              vend_valid <= 1'b1;
              vend_idx   <= sel_idx;
            end
          end else begin
            if (left_ev && !right_ev)
              sel_idx <= (sel_idx == '0) ? IW'(N_ITEMS-1) : sel_idx - IW'(1);
            else if (right_ev && !left_ev)
              sel_idx <= (sel_idx == IW'(N_ITEMS-1)) ? '0 : sel_idx + IW'(1);
            if (|coin_ev) begin
              if (coin_sum > MAXC) begin
                coin_reject <= 1'b1;
              end else begin
                credit      <= coin_sum[PW-1:0];
                coin_reject <= multi_coin;
              end
            end
          end
        end
        VEND: begin
          coin_reject <= |coin_ev;
          if (vend_ready) begin
            vend_valid <= 1'b0;
            credit     <= vend_rem;
            if (vend_rem != '0) begin
              state     <= CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= vend_coin;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= |coin_ev;
          if (chg_ready) begin
            credit <= chg_rem;
            if (chg_rem == '0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              chg_valid <= 1'b0;
              chg_coin  <= '0;
            end else begin
              chg_coin <= next_coin;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          vend_valid <= 1'b0;
          chg_valid  <= 1'b0;
          chg_coin   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// tb_vend_ctrl_multi: randomized scoreboard bench for vend_ctrl_multi against a
// credit/selection model built from the price and coin tables.
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] coin_in;
  logic       btn_left, btn_right, btn_confirm, btn_cancel;
  logic [6:0] credit, sel_price;
  logic [2:0] sel_idx, vend_idx;
  logic [4:0] afford;
  logic       vend_valid, vend_ready, chg_valid, chg_ready, coin_reject, busy;
  logic [3:0] chg_coin;

  vend_ctrl_multi dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_confirm (btn_confirm),
    .btn_cancel  (btn_cancel),
    .credit      (credit),
    .sel_idx     (sel_idx),
    .sel_price   (sel_price),
    .afford      (afford),
    .vend_valid  (vend_valid),
    .vend_idx    (vend_idx),
    .vend_ready  (vend_ready),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .chg_ready   (chg_ready),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int prices [5] = '{7, 5, 6, 10, 8};
  int coin_v [4] = '{1, 5, 10, 20};
  int m_credit, m_sel;
  int n_chk = 0, n_pass = 0;
  int rdy_mode = 0;
  int exp_vend [$];
  int exp_chg  [$];
  int exp_rej  [$];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Greedy change: always the largest coin that still fits.
  task automatic push_change(int amount);
    int c, k;
    c = amount;
    while (c > 0) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (coin_v[i] <= c) k = i;
      exp_chg.push_back(1 << k);
      c -= coin_v[k];
    end
  endtask

  task automatic check_state(string tag);
    int exp_aff;
    exp_aff = 0;
    for (int i = 0; i < 5; i++) if (m_credit >= prices[i]) exp_aff |= (1 << i);
    check({tag, "_credit"}, int'(credit), m_credit);
    check({tag, "_sel"}, int'(sel_idx), m_sel);
    check({tag, "_price"}, int'(sel_price), prices[m_sel]);
    check({tag, "_afford"}, int'(afford), exp_aff);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic do_coin(logic [3:0] bits);
    int  k;
    bit  rej;
    k = 0;
    for (int i = 0; i < 4; i++) if (bits[i]) k = i;
    rej = ($countones(bits) > 1);
    if (m_credit + coin_v[k] > 99) rej = 1'b1;
    else m_credit += coin_v[k];
    if (rej) exp_rej.push_back(1);
    coin_in = bits;
    step();
    coin_in = '0;
    step();
  endtask

  task automatic do_nav(logic l, logic r);
    if (l && !r) m_sel = (m_sel + 4) % 5;
    if (r && !l) m_sel = (m_sel + 1) % 5;
    btn_left  = l;
    btn_right = r;
    step();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    step();
  endtask

  task automatic do_confirm();
    if (m_credit >= prices[m_sel]) begin
      exp_vend.push_back(m_sel);
      m_credit -= prices[m_sel];
      push_change(m_credit);
      m_credit = 0;
    end
    btn_confirm = 1'b1;
    step();
    btn_confirm = 1'b0;
    wait_idle("confirm_done");
  endtask

  task automatic do_cancel();
    push_change(m_credit);
    m_credit = 0;
    btn_cancel = 1'b1;
    step();
    btn_cancel = 1'b0;
    wait_idle("cancel_done");
  endtask

  initial begin
    vend_ready = 1'b0;
    chg_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin
          vend_ready = 1'($urandom_range(0, 1));
          chg_ready  = 1'($urandom_range(0, 1));
        end
        1: begin vend_ready = 1'b1; chg_ready = 1'b1; end
        default: begin vend_ready = 1'b0; chg_ready = 1'b0; end
      endcase
    end
  end

  initial begin
    bit vstall, cstall;
    int vprev, cprev;
    vstall = 1'b0;
    cstall = 1'b0;
    vprev  = 0;
    cprev  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        vstall = 1'b0;
        cstall = 1'b0;
      end else begin
        if (vstall) begin
          check("vend_hold_valid", int'(vend_valid), 1);
          check("vend_hold_idx", int'(vend_idx), vprev);
        end
        if (cstall) begin
          check("chg_hold_valid", int'(chg_valid), 1);
          check("chg_hold_coin", int'(chg_coin), cprev);
        end
        if (vend_valid && vend_ready) begin
          check("vend_expected", int'(exp_vend.size() > 0), 1);
          if (exp_vend.size() > 0) check("vend_idx", int'(vend_idx), exp_vend.pop_front());
        end
        if (chg_valid && chg_ready) begin
          check("chg_expected", int'(exp_chg.size() > 0), 1);
          if (exp_chg.size() > 0) check("chg_coin", int'(chg_coin), exp_chg.pop_front());
        end
        if (coin_reject) begin
          check("reject_expected", int'(exp_rej.size() > 0), 1);
          if (exp_rej.size() > 0) void'(exp_rej.pop_front());
        end
        vstall = vend_valid && !vend_ready;
        cstall = chg_valid && !chg_ready;
        vprev  = int'(vend_idx);
        cprev  = int'(chg_coin);
      end
    end
  end

  initial begin
    int r;
    rst = 1'b0;
    coin_in = '0;
    btn_left = 1'b0; btn_right = 1'b0; btn_confirm = 1'b0; btn_cancel = 1'b0;
    m_credit = 0;
    m_sel = 0;
    repeat (3) step();
    check("rst_credit", int'(credit), 0);
    check("rst_vend_valid", int'(vend_valid), 0);
    check("rst_chg_valid", int'(chg_valid), 0);
    rst = 1'b1;
    step();
    check_state("reset");

    rdy_mode = 1;
    do_coin(4'b0100);
    do_coin(4'b0001);
    check_state("credit11");
    do_cancel();
    check_state("refund11");

    repeat (4) do_coin(4'b1000);
    check_state("credit80");
    do_coin(4'b1000);
    check_state("over80");
    do_coin(4'b0100);
    check_state("credit90");
    do_coin(4'b1000);
    check_state("over90");

    do_nav(1'b1, 1'b0);
    check_state("left_wrap");
    do_nav(1'b0, 1'b1);
    check_state("right_wrap");

    do_cancel();
    do_coin(4'b0010);
    do_coin(4'b0001);
    do_confirm();
    check_state("confirm_poor");
    do_nav(1'b0, 1'b1);
    do_nav(1'b0, 1'b1);
    check_state("sel2");

    rdy_mode = 2;
    step();
    exp_vend.push_back(2);
    m_credit = 0;
    btn_confirm = 1'b1;
    step();
    btn_confirm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", int'(vend_valid), 1);
      check("stall_idx", int'(vend_idx), 2);
      step();
    end
    rdy_mode = 1;
    wait_idle("vend_done");
    check_state("after_vend");
    check("no_change", int'(chg_valid), 0);

    do_coin(4'b0100);
    do_coin(4'b0010);
    do_coin(4'b0001);
    do_coin(4'b0001);
    check_state("credit17");
    push_change(17);
    m_credit = 0;
    btn_cancel = 1'b1;
    step();
    btn_cancel = 1'b0;
    coin_in = 4'b0010;
    exp_rej.push_back(1);
    step();
    coin_in = '0;
    wait_idle("change17_done");
    check_state("after_change17");

    do_coin(4'b1000);
    do_coin(4'b0100);
    rdy_mode = 2;
    step();
    btn_cancel = 1'b1;
    step();
    btn_cancel = 1'b0;
    step();
    check("mid_chg_valid", int'(chg_valid), 1);
    check("mid_chg_coin", int'(chg_coin), 8);
    #2;
    rst = 1'b0;
    #1;
    check("async_credit", int'(credit), 0);
    check("async_sel", int'(sel_idx), 0);
    check("async_chg_valid", int'(chg_valid), 0);
    check("async_chg_coin", int'(chg_coin), 0);
    check("async_vend_valid", int'(vend_valid), 0);
    check("async_reject", int'(coin_reject), 0);
    check("async_busy", int'(busy), 0);
    m_credit = 0;
    m_sel = 0;
    exp_chg.delete();
    step();
    step();
    rst = 1'b1;
    rdy_mode = 0;
    step();
    check_state("after_async");

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: do_coin(4'(1 << $urandom_range(0, 3)));
        4:          do_coin(4'($urandom_range(1, 15)));
        5:          do_nav(1'b1, 1'b0);
        6:          do_nav(1'b0, 1'b1);
        7:          do_nav(1'b1, 1'b1);
        8:          do_confirm();
        default:    do_cancel();
      endcase
      check_state("rand");
    end

    repeat (3) step();
    check("vend_q_empty", exp_vend.size(), 0);
    check("chg_q_empty", exp_chg.size(), 0);
    check("rej_q_empty", exp_rej.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
